// File: rtl/z_core_mem_arbiter.sv
// Two-requester round-robin arbiter in front of the AXI-Lite master's simple memory port.
// Each requester owns a one-entry pending buffer; one downstream transaction is in flight at a time.
module z_core_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_m0_req,
  input  logic                  i_m0_wen,
  input  logic [ADDR_WIDTH-1:0] i_m0_addr,
  input  logic [DATA_WIDTH-1:0] i_m0_wdata,
  input  logic [STRB_WIDTH-1:0] i_m0_wstrb,
  output logic [DATA_WIDTH-1:0] o_m0_rdata,
  output logic                  o_m0_ready,
  output logic                  o_m0_busy,
  input  logic                  i_m1_req,
  input  logic                  i_m1_wen,
  input  logic [ADDR_WIDTH-1:0] i_m1_addr,
  input  logic [DATA_WIDTH-1:0] i_m1_wdata,
  input  logic [STRB_WIDTH-1:0] i_m1_wstrb,
  output logic [DATA_WIDTH-1:0] o_m1_rdata,
  output logic                  o_m1_ready,
  output logic                  o_m1_busy,
  output logic                  o_mem_req,
  output logic                  o_mem_wen,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [STRB_WIDTH-1:0] o_mem_wstrb,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_ready,
  input  logic                  i_mem_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                       r_state;
  logic                         r_grant;
  logic                         r_lastGrant;
  logic [1:0]                   r_pend;
  logic [1:0]                   r_pWen;
  logic [1:0][ADDR_WIDTH-1:0]   r_pAddr;
  logic [1:0][DATA_WIDTH-1:0]   r_pWdata;
  logic [1:0][STRB_WIDTH-1:0]   r_pWstrb;

  logic [1:0]                   w_req;
  logic [1:0]                   w_wenIn;
  logic [1:0][ADDR_WIDTH-1:0]   w_addrIn;
  logic [1:0][DATA_WIDTH-1:0]   w_wdataIn;
  logic [1:0][STRB_WIDTH-1:0]   w_wstrbIn;
  logic                         w_done;
  logic [1:0]                   w_clr;
  logic                         w_winner;

  assign w_req     = {i_m1_req, i_m0_req};
  assign w_wenIn   = {i_m1_wen, i_m0_wen};
  assign w_addrIn  = {i_m1_addr, i_m0_addr};
  assign w_wdataIn = {i_m1_wdata, i_m0_wdata};
  assign w_wstrbIn = {i_m1_wstrb, i_m0_wstrb};

  assign w_done   = (r_state == WAIT) && i_mem_ready;
  assign w_clr[0] = w_done && !r_grant;
  assign w_clr[1] = w_done && r_grant;

  // With both ports waiting, the one that was not served last goes next.
  assign w_winner = (&r_pend) ? ~r_lastGrant : r_pend[1];

  // A freed slot can be refilled on the very edge that completes its previous request.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pend   <= '0;
      r_pWen   <= '0;
      r_pAddr  <= '0;
      r_pWdata <= '0;
      r_pWstrb <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (w_req[n] && (!r_pend[n] || w_clr[n])) begin
          r_pend[n]   <= 1'b1;
          r_pWen[n]   <= w_wenIn[n];
          r_pAddr[n]  <= w_addrIn[n];
          r_pWdata[n] <= w_wdataIn[n];
          r_pWstrb[n] <= w_wstrbIn[n];
        end else if (w_clr[n]) begin
          r_pend[n] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_grant     <= 1'b0;
      r_lastGrant <= 1'b1;
      o_mem_req   <= 1'b0;
      o_mem_wen   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_wstrb <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if ((|r_pend) && !i_mem_busy) begin
            r_grant     <= w_winner;
            o_mem_req   <= 1'b1;
            o_mem_wen   <= r_pWen[w_winner];
            o_mem_addr  <= r_pAddr[w_winner];
            o_mem_wdata <= r_pWdata[w_winner];
            o_mem_wstrb <= r_pWstrb[w_winner];
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          o_mem_req <= 1'b0;
          r_state   <= WAIT;
        end
        WAIT: begin
          if (i_mem_ready) begin
            r_lastGrant <= r_grant;
            r_state     <= IDLE;
          end
        end
        default: begin
          o_mem_req <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  // Gating with rstn keeps ready/busy quiet for the whole reset window, not just after the edge.
  assign o_m0_ready = rstn && w_done && !r_grant;
  assign o_m1_ready = rstn && w_done && r_grant;
  assign o_m0_busy  = rstn && r_pend[0];
  assign o_m1_busy  = rstn && r_pend[1];
  assign o_m0_rdata = i_mem_rdata;
  assign o_m1_rdata = i_mem_rdata;

endmodule

// File: tb/tb_z_core_mem_arbiter.sv
// Directed self-checking bench for z_core_mem_arbiter with a one-cycle-latency downstream responder.
module tb_z_core_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_m0_req = 1'b0, i_m0_wen = 1'b0;
  logic [31:0] i_m0_addr = '0, i_m0_wdata = '0;
  logic [3:0]  i_m0_wstrb = '0;
  logic        i_m1_req = 1'b0, i_m1_wen = 1'b0;
  logic [31:0] i_m1_addr = '0, i_m1_wdata = '0;
  logic [3:0]  i_m1_wstrb = '0;
  logic [31:0] o_m0_rdata, o_m1_rdata;
  logic        o_m0_ready, o_m0_busy, o_m1_ready, o_m1_busy;
  logic        o_mem_req, o_mem_wen;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_wstrb;
  logic [31:0] i_mem_rdata = '0;
  logic        i_mem_ready = 1'b0;
  logic        i_mem_busy = 1'b0;

  z_core_mem_arbiter dut (
    .clk(clk), .rstn(rstn),
    .i_m0_req(i_m0_req), .i_m0_wen(i_m0_wen), .i_m0_addr(i_m0_addr),
    .i_m0_wdata(i_m0_wdata), .i_m0_wstrb(i_m0_wstrb),
    .o_m0_rdata(o_m0_rdata), .o_m0_ready(o_m0_ready), .o_m0_busy(o_m0_busy),
    .i_m1_req(i_m1_req), .i_m1_wen(i_m1_wen), .i_m1_addr(i_m1_addr),
    .i_m1_wdata(i_m1_wdata), .i_m1_wstrb(i_m1_wstrb),
    .o_m1_rdata(o_m1_rdata), .o_m1_ready(o_m1_ready), .o_m1_busy(o_m1_busy),
    .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready), .i_mem_busy(i_mem_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          cyc;
  } memTxn_t;

  memTxn_t     memLog[$];
  int          readyOrder[$];
  int          checkCount = 0;
  int          failCount = 0;
  int          cyc = 0;
  int          m0Cnt = 0, m1Cnt = 0;
  int          readyCyc = 0, reqCyc = 0;
  logic [31:0] lastRdata0 = '0;
  logic        autoResp = 1'b1;
  logic        sawReq = 1'b0;
  logic [31:0] sawAddr = '0;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] respFor(input logic [31:0] addr);
    return (addr == 32'h100) ? 32'hDEADBEEF : ~addr;
  endfunction

  // Monitor samples mid-cycle; the responder answers in the cycle after each mem_req.
  always @(negedge clk) begin
    sawReq  = o_mem_req;
    sawAddr = o_mem_addr;
    if (o_mem_req) memLog.push_back('{o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wstrb, cyc});
    if (o_m0_ready) begin
      m0Cnt++;
      readyOrder.push_back(0);
      lastRdata0 = o_m0_rdata;
      readyCyc = cyc;
    end
    if (o_m1_ready) begin
      m1Cnt++;
      readyOrder.push_back(1);
      readyCyc = cyc;
    end
  end

  always @(posedge clk) begin
    #1;
    if (autoResp) begin
      i_mem_ready = sawReq;
      i_mem_rdata = sawReq ? respFor(sawAddr) : 32'h0;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives a one-cycle request pulse; entered and left just after a rising edge.
  task automatic applyStimulus(input int port, input logic wen, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb);
    reqCyc = cyc;
    if (port == 0) begin
      i_m0_req = 1'b1; i_m0_wen = wen; i_m0_addr = addr; i_m0_wdata = wdata; i_m0_wstrb = wstrb;
    end else begin
      i_m1_req = 1'b1; i_m1_wen = wen; i_m1_addr = addr; i_m1_wdata = wdata; i_m1_wstrb = wstrb;
    end
    @(posedge clk); #1;
    i_m0_req = 1'b0;
    i_m1_req = 1'b0;
  endtask

  task automatic waitReadies(input int target, input int budget, input string tag);
    logic timedOut;
    timedOut = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (m0Cnt + m1Cnt >= target) begin
        timedOut = 1'b0;
        break;
      end
    end
    checkOutput({tag, "_timeout"}, timedOut, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic clearLogs();
    memLog.delete();
    readyOrder.delete();
    m0Cnt = 0;
    m1Cnt = 0;
  endtask

  task automatic resetDut();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  function automatic logic [31:0] logAddr(input int i);
    return (memLog.size() > i) ? memLog[i].addr : 32'hFFFF_FFFF;
  endfunction

  initial begin
    int issued0, issued1, seen0, seen1, minGap, lastBusyCyc;
    logic busyLow, reqWhileBusy, timedOut;

    // Reset state; a request held during reset must not be captured
    i_m0_req = 1'b1; i_m0_addr = 32'hBAD;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_m0_busy_during", o_m0_busy, 1'b0);
    checkOutput("rst_m0_ready_during", o_m0_ready, 1'b0);
    @(posedge clk); #1;
    i_m0_req = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("rst_mem_req", o_mem_req, 1'b0);
    checkOutput("rst_mem_wen", o_mem_wen, 1'b0);
    checkOutput("rst_mem_addr", o_mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", o_mem_wdata, 32'h0);
    checkOutput("rst_mem_wstrb", o_mem_wstrb, 4'h0);
    checkOutput("rst_busy", {o_m0_busy, o_m1_busy}, 2'b00);
    @(posedge clk); #1;

    // Single read with minimum latency
    clearLogs();
    applyStimulus(0, 1'b0, 32'h100, 32'h0, 4'hF);
    waitReadies(1, 20, "single");
    checkOutput("single_nreq", memLog.size(), 1);
    checkOutput("single_addr", logAddr(0), 32'h100);
    checkOutput("single_wen", (memLog.size() > 0) ? memLog[0].wen : 1'b1, 1'b0);
    checkOutput("single_memreq_lat", (memLog.size() > 0) ? memLog[0].cyc - reqCyc : -1, 2);
    checkOutput("single_ready_lat", readyCyc - reqCyc, 3);
    checkOutput("single_rdata", lastRdata0, 32'hDEADBEEF);
    checkOutput("single_m0cnt", m0Cnt, 1);
    checkOutput("single_m1cnt", m1Cnt, 0);

    // Simultaneous requests right after reset: port 0 first
    resetDut();
    clearLogs();
    i_m1_req = 1'b1; i_m1_wen = 1'b1; i_m1_addr = 32'h20; i_m1_wdata = 32'h55AA55AA; i_m1_wstrb = 4'b0101;
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'hF);
    waitReadies(2, 30, "simul");
    checkOutput("simul_nreq", memLog.size(), 2);
    checkOutput("simul_addr0", logAddr(0), 32'h10);
    checkOutput("simul_addr1", logAddr(1), 32'h20);
    checkOutput("simul_wen1", (memLog.size() > 1) ? memLog[1].wen : 1'b0, 1'b1);
    checkOutput("simul_wdata1", (memLog.size() > 1) ? memLog[1].wdata : 32'h0, 32'h55AA55AA);
    checkOutput("simul_wstrb1", (memLog.size() > 1) ? memLog[1].wstrb : 4'h0, 4'b0101);
    checkOutput("simul_order", {(readyOrder.size() > 0) ? readyOrder[0] : 9, (readyOrder.size() > 1) ? readyOrder[1] : 9}, {32'd0, 32'd1});
    checkOutput("simul_counts", {m0Cnt, m1Cnt}, {32'd1, 32'd1});

    // Fairness: both ports re-request right after each completion
    clearLogs();
    issued0 = 1; issued1 = 1; seen0 = 0; seen1 = 0;
    i_m1_req = 1'b1; i_m1_wen = 1'b1; i_m1_addr = 32'h2000; i_m1_wdata = 32'h1;
    i_m0_req = 1'b1; i_m0_wen = 1'b0; i_m0_addr = 32'h1000;
    timedOut = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      i_m0_req = 1'b0;
      i_m1_req = 1'b0;
      if (m0Cnt + m1Cnt >= 8) begin
        timedOut = 1'b0;
        break;
      end
      if (m0Cnt > seen0) begin
        seen0 = m0Cnt;
        if (issued0 < 4) begin i_m0_req = 1'b1; i_m0_addr = 32'h1000 + issued0; issued0++; end
      end
      if (m1Cnt > seen1) begin
        seen1 = m1Cnt;
        if (issued1 < 4) begin i_m1_req = 1'b1; i_m1_addr = 32'h2000 + issued1; issued1++; end
      end
    end
    checkOutput("fair_timeout", timedOut, 1'b0);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("fair_grant%0d", i), (readyOrder.size() > i) ? readyOrder[i] : 9, i % 2);
    checkOutput("fair_counts", {m0Cnt, m1Cnt}, {32'd4, 32'd4});
    minGap = 1000;
    for (int i = 1; i < memLog.size(); i++)
      if (memLog[i].cyc - memLog[i-1].cyc < minGap) minGap = memLog[i].cyc - memLog[i-1].cyc;
    checkOutput("fair_min_gap", minGap, 3);

    // Back-pressure: downstream busy for 5 cycles with port 1 pending
    clearLogs();
    @(posedge clk); #1;
    i_mem_busy = 1'b1;
    reqWhileBusy = 1'b0;
    busyLow = 1'b0;
    applyStimulus(1, 1'b0, 32'h500, 32'h0, 4'hF);
    repeat (4) begin
      @(negedge clk);
      reqWhileBusy |= o_mem_req;
      busyLow |= !o_m1_busy;
      @(posedge clk); #1;
    end
    lastBusyCyc = cyc - 1;
    i_mem_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_m1_ready) break;
      busyLow |= !o_m1_busy;
    end
    waitReadies(1, 10, "bp");
    checkOutput("bp_no_req_while_busy", reqWhileBusy, 1'b0);
    checkOutput("bp_busy_held", busyLow, 1'b0);
    checkOutput("bp_issue_delay", (memLog.size() > 0) ? memLog[0].cyc - lastBusyCyc : -1, 2);
    checkOutput("bp_m1cnt", m1Cnt, 1);

    // Second request while the first is still pending is dropped
    clearLogs();
    applyStimulus(0, 1'b0, 32'h100, 32'h0, 4'hF);
    applyStimulus(0, 1'b0, 32'h200, 32'h0, 4'hF);
    waitReadies(1, 20, "drop");
    repeat (6) @(posedge clk);
    #1;
    checkOutput("drop_nreq", memLog.size(), 1);
    checkOutput("drop_addr", logAddr(0), 32'h100);
    checkOutput("drop_m0cnt", m0Cnt, 1);

    // Reset while waiting for the response, then a late mem_ready
    clearLogs();
    autoResp = 1'b0;
    i_mem_ready = 1'b0;
    applyStimulus(0, 1'b0, 32'h300, 32'h0, 4'hF);
    timedOut = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_mem_req) begin timedOut = 1'b0; break; end
    end
    checkOutput("rstwait_req_timeout", timedOut, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b0;
    i_mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("rstwait_ready_in_rst", {o_m0_ready, o_m1_ready}, 2'b00);
    checkOutput("rstwait_busy_in_rst", {o_m0_busy, o_m1_busy}, 2'b00);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("rstwait_late_ready", {o_m0_ready, o_m1_ready}, 2'b00);
    checkOutput("rstwait_busy_after", {o_m0_busy, o_m1_busy}, 2'b00);
    checkOutput("rstwait_memreq_after", o_mem_req, 1'b0);
    @(posedge clk); #1;
    i_mem_ready = 1'b0;
    autoResp = 1'b1;
    checkOutput("rstwait_m0cnt", m0Cnt, 0);
    applyStimulus(1, 1'b0, 32'h400, 32'h0, 4'hF);
    waitReadies(1, 20, "rstwait_next");
    checkOutput("rstwait_next_addr", logAddr(1), 32'h400);
    checkOutput("rstwait_next_counts", {m0Cnt, m1Cnt}, {32'd0, 32'd1});

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
